// File: rtl/beat_step_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// beat_step_sequencer_ctrl
//
// Transport and tempo controller for the 16-step switch-pattern tone datapath.
// It produces the beat index (four beats per step, BEAT_COUNT beats per
// pattern) and the play enable that the tone/LED datapath consumes. It
// supports play/pause/stop, one-shot or looped playback and four tempo levels.
//
// Parameters
//   BASE_DIV    clock cycles per beat at the fastest tempo
//   BEAT_COUNT  beats per pattern; the last valid beat is BEAT_COUNT-1
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   play_btn   one-cycle pulse: start / pause / resume
//   stop_btn   one-cycle pulse: stop and rewind to beat 0
//   tempo_up   one-cycle pulse: faster tempo (saturates at 3)
//   tempo_dn   one-cycle pulse: slower tempo (saturates at 0)
//   loop_mode  level: 1 = wrap at pattern end, 0 = one-shot
//   ibeatNum   beat index to the datapath (BEAT_COUNT while in END)
//   en         datapath play enable
//   step       current step, ibeatNum[5:2]; 0 in END
//   tempo      tempo level, 0 = slowest, 3 = fastest
//   state      IDLE=00, PLAY=01, PAUSE=10, END=11
//   done       one-cycle pattern-complete pulse
// -----------------------------------------------------------------------------
module beat_step_sequencer_ctrl #(
    parameter int unsigned BASE_DIV   = 25_000_000,
    parameter int unsigned BEAT_COUNT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_btn,
    input  logic        stop_btn,
    input  logic        tempo_up,
    input  logic        tempo_dn,
    input  logic        loop_mode,
    output logic [11:0] ibeatNum,
    output logic        en,
    output logic [3:0]  step,
    output logic [1:0]  tempo,
    output logic [1:0]  state,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_END   = 2'b11
    } state_t;

    localparam logic [11:0] LAST_BEAT = 12'(BEAT_COUNT - 1);
    localparam logic [11:0] END_BEAT  = 12'(BEAT_COUNT);

    state_t      r_state;
    logic [11:0] r_beat;
    logic        r_en;
    logic [3:0]  r_step;
    logic [1:0]  r_tempo;
    logic        r_done;
    logic [31:0] r_presc;

    logic [31:0] w_div;
    logic        w_tick;
    logic [11:0] w_beat_inc;

    // Divisor follows the registered tempo, so a tempo change takes effect
    // on the cycle after it is accepted.
    assign w_div      = 32'(BASE_DIV) * (32'd4 - {30'd0, r_tempo});
    // ">=" rather than "==" so a shorter divisor ticks at once instead of
    // letting the prescaler run past it.
    assign w_tick     = (r_state == ST_PLAY) && (r_presc >= (w_div - 32'd1));
    assign w_beat_inc = r_beat + 12'd1;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= 12'd0;
            r_en    <= 1'b0;
            r_step  <= 4'd0;
            r_tempo <= 2'd1;
            r_done  <= 1'b0;
            r_presc <= 32'd0;
        end else begin
            r_done <= 1'b0;

            // Tempo is independent of transport and accepted in every state.
            if (tempo_up && !tempo_dn && (r_tempo != 2'd3)) begin
                r_tempo <= r_tempo + 2'd1;
            end else if (tempo_dn && !tempo_up && (r_tempo != 2'd0)) begin
                r_tempo <= r_tempo - 2'd1;
            end

            // Transport buttons take precedence over a coincident tick; the
            // tick's beat advance is simply dropped.
            if (stop_btn) begin
                r_state <= ST_IDLE;
                r_beat  <= 12'd0;
                r_step  <= 4'd0;
                r_en    <= 1'b0;
                r_presc <= 32'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (play_btn) begin
                            r_state <= ST_PLAY;
                            r_en    <= 1'b1;
                            r_beat  <= 12'd0;
                            r_step  <= 4'd0;
                            r_presc <= 32'd0;
                        end
                    end
                    ST_PLAY: begin
                        if (play_btn) begin
                            // Prescaler is left as-is so resume finishes the
                            // partially counted beat.
                            r_state <= ST_PAUSE;
                            r_en    <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= 32'd0;
                            if (r_beat == LAST_BEAT) begin
                                r_done <= 1'b1;
                                r_step <= 4'd0;
                                if (loop_mode) begin
                                    r_beat <= 12'd0;
                                end else begin
                                    r_state <= ST_END;
                                    r_beat  <= END_BEAT;
                                end
                            end else begin
                                r_beat <= w_beat_inc;
                                r_step <= w_beat_inc[5:2];
                            end
                        end else begin
                            r_presc <= r_presc + 32'd1;
                        end
                    end
                    ST_PAUSE: begin
                        if (play_btn) begin
                            r_state <= ST_PLAY;
                            r_en    <= 1'b1;
                        end
                    end
                    ST_END: begin
                        if (play_btn) begin
                            r_state <= ST_PLAY;
                            r_beat  <= 12'd0;
                            r_step  <= 4'd0;
                            r_presc <= 32'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ibeatNum = r_beat;
    assign en       = r_en;
    assign step     = r_step;
    assign tempo    = r_tempo;
    assign state    = r_state;
    assign done     = r_done;

endmodule

// File: tb/tb_beat_step_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beat_step_sequencer_ctrl
//
// Directed bench for beat_step_sequencer_ctrl with BASE_DIV=4, BEAT_COUNT=64.
// A vector table covers tempo saturation and the first beats of playback;
// hand-written sequences cover one-shot end, pause/resume, looping, tempo
// timing, button priority and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_beat_step_sequencer_ctrl;

    localparam int unsigned BASE_DIV   = 4;
    localparam int unsigned BEAT_COUNT = 64;

    logic        clk;
    logic        rst;
    logic        play_btn;
    logic        stop_btn;
    logic        tempo_up;
    logic        tempo_dn;
    logic        loop_mode;
    logic [11:0] ibeatNum;
    logic        en;
    logic [3:0]  step;
    logic [1:0]  tempo;
    logic [1:0]  state;
    logic        done;

    beat_step_sequencer_ctrl #(
        .BASE_DIV   (BASE_DIV),
        .BEAT_COUNT (BEAT_COUNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play_btn  (play_btn),
        .stop_btn  (stop_btn),
        .tempo_up  (tempo_up),
        .tempo_dn  (tempo_dn),
        .loop_mode (loop_mode),
        .ibeatNum  (ibeatNum),
        .en        (en),
        .step      (step),
        .tempo     (tempo),
        .state     (state),
        .done      (done)
    );

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_END   = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        play;
        logic        stop;
        logic        up;
        logic        dn;
        int          cycles;
        logic [1:0]  e_state;
        logic [11:0] e_beat;
        logic        e_en;
        logic [3:0]  e_step;
        logic [1:0]  e_tempo;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic p, input logic s, input logic u,
                                input logic d, input int c, input logic [1:0] st,
                                input logic [11:0] b, input logic e,
                                input logic [3:0] sp, input logic [1:0] t);
        vec_t v;
        v.play = p; v.stop = s; v.up = u; v.dn = d; v.cycles = c;
        v.e_state = st; v.e_beat = b; v.e_en = e; v.e_step = sp; v.e_tempo = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st,
                             input logic [11:0] b, input logic e,
                             input logic [3:0] sp, input logic [1:0] t,
                             input logic d);
        check({tag, ".state"}, 32'(state),    32'(st));
        check({tag, ".beat"},  32'(ibeatNum), 32'(b));
        check({tag, ".en"},    32'(en),       32'(e));
        check({tag, ".step"},  32'(step),     32'(sp));
        check({tag, ".tempo"}, 32'(tempo),    32'(t));
        check({tag, ".done"},  32'(done),     32'(d));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic apply(input logic p, input logic s, input logic u, input logic d);
        play_btn = p; stop_btn = s; tempo_up = u; tempo_dn = d;
        cyc();
        play_btn = 1'b0; stop_btn = 1'b0; tempo_up = 1'b0; tempo_dn = 1'b0;
    endtask

    int en_drops;

    initial begin
        rst = 1'b1; play_btn = 1'b0; stop_btn = 1'b0;
        tempo_up = 1'b0; tempo_dn = 1'b0; loop_mode = 1'b0;
        run(3);
        check_all("reset", S_IDLE, 12'd0, 1'b0, 4'd0, 2'd1, 1'b0);
        rst = 1'b0;
        cyc();

        //               play stop up  dn  cyc state    beat   en  step tempo
        vecs[0]  = mk(0, 0, 1, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd2);
        vecs[1]  = mk(0, 0, 1, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd3);
        vecs[2]  = mk(0, 0, 1, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd3);
        vecs[3]  = mk(0, 0, 1, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd3);
        vecs[4]  = mk(0, 0, 0, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd2);
        vecs[5]  = mk(0, 0, 0, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd1);
        vecs[6]  = mk(0, 0, 0, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd0);
        vecs[7]  = mk(0, 0, 0, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd0);
        vecs[8]  = mk(0, 0, 1, 1,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd0);
        vecs[9]  = mk(0, 0, 1, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd1);
        vecs[10] = mk(0, 1, 0, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd1);
        vecs[11] = mk(1, 0, 0, 0,  1, S_PLAY, 12'd0, 1, 4'd0, 2'd1);
        vecs[12] = mk(0, 0, 0, 0, 11, S_PLAY, 12'd0, 1, 4'd0, 2'd1);
        vecs[13] = mk(0, 0, 0, 0,  1, S_PLAY, 12'd1, 1, 4'd0, 2'd1);
        vecs[14] = mk(0, 0, 0, 0, 36, S_PLAY, 12'd4, 1, 4'd1, 2'd1);
        vecs[15] = mk(0, 1, 0, 0,  1, S_IDLE, 12'd0, 0, 4'd0, 2'd1);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].play, vecs[i].stop, vecs[i].up, vecs[i].dn);
            run(vecs[i].cycles - 1);
            check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_beat,
                      vecs[i].e_en, vecs[i].e_step, vecs[i].e_tempo, 1'b0);
        end

        // One-shot run at D=12: END exactly 768 cycles after PLAY entry.
        apply(1, 0, 0, 0);
        run(767);
        check_all("oneshot_last", S_PLAY, 12'd63, 1'b1, 4'd15, 2'd1, 1'b0);
        cyc();
        check_all("oneshot_end", S_END, 12'd64, 1'b1, 4'd0, 2'd1, 1'b1);
        cyc();
        check_all("oneshot_hold", S_END, 12'd64, 1'b1, 4'd0, 2'd1, 1'b0);
        apply(1, 0, 0, 0);
        check_all("end_replay", S_PLAY, 12'd0, 1'b1, 4'd0, 2'd1, 1'b0);
        run(12);
        check("end_replay_b1", 32'(ibeatNum), 32'd1);

        // Pause at beat 5 with prescaler 7; resume needs 5 more cycles.
        apply(0, 1, 0, 0);
        apply(1, 0, 0, 0);
        run(67);
        check("pre_pause_beat", 32'(ibeatNum), 32'd5);
        apply(1, 0, 0, 0);
        check_all("paused", S_PAUSE, 12'd5, 1'b0, 4'd1, 2'd1, 1'b0);
        run(100);
        check_all("paused_hold", S_PAUSE, 12'd5, 1'b0, 4'd1, 2'd1, 1'b0);
        apply(1, 0, 0, 0);
        check_all("resumed", S_PLAY, 12'd5, 1'b1, 4'd1, 2'd1, 1'b0);
        run(4);
        check("resume_4cyc", 32'(ibeatNum), 32'd5);
        cyc();
        check("resume_5cyc", 32'(ibeatNum), 32'd6);

        // Loop mode: wrap to beat 0 with a done pulse and no enable gap.
        apply(0, 1, 0, 0);
        loop_mode = 1'b1;
        apply(1, 0, 0, 0);
        en_drops = 0;
        for (int i = 0; i < 767; i++) begin
            cyc();
            if (!en) en_drops++;
        end
        check_all("loop_last", S_PLAY, 12'd63, 1'b1, 4'd15, 2'd1, 1'b0);
        cyc();
        if (!en) en_drops++;
        check_all("loop_wrap", S_PLAY, 12'd0, 1'b1, 4'd0, 2'd1, 1'b1);
        cyc();
        if (!en) en_drops++;
        check_all("loop_after", S_PLAY, 12'd0, 1'b1, 4'd0, 2'd1, 1'b0);
        check("loop_en_drops", 32'(en_drops), 32'd0);
        loop_mode = 1'b0;

        // Fastest tempo: beat every 4 cycles.
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 1, 0);
        check("tempo_sat3", 32'(tempo), 32'd3);
        apply(1, 0, 0, 0);
        run(3);
        check("t3_beat0", 32'(ibeatNum), 32'd0);
        cyc();
        check("t3_beat1", 32'(ibeatNum), 32'd1);
        run(4);
        check("t3_beat2", 32'(ibeatNum), 32'd2);

        // Slowest tempo: beat every 16 cycles.
        apply(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1);
        check("tempo_sat0", 32'(tempo), 32'd0);
        apply(1, 0, 0, 0);
        run(15);
        check("t0_beat0", 32'(ibeatNum), 32'd0);
        cyc();
        check("t0_beat1", 32'(ibeatNum), 32'd1);

        // Tempo up at prescaler 10 (D 12 -> 8) ticks on the following cycle.
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 0);
        apply(1, 0, 0, 0);
        run(10);
        apply(0, 0, 1, 0);
        check("midbeat_tempo", 32'(tempo), 32'd2);
        check("midbeat_beat0", 32'(ibeatNum), 32'd0);
        cyc();
        check("midbeat_tick", 32'(ibeatNum), 32'd1);
        run(8);
        check("midbeat_d8", 32'(ibeatNum), 32'd2);

        // Stop wins over play, in PLAY and in PAUSE (D=8).
        apply(0, 1, 0, 0);
        apply(1, 0, 0, 0);
        run(240);
        check("pri_beat30", 32'(ibeatNum), 32'd30);
        apply(1, 1, 0, 0);
        check_all("pri_play", S_IDLE, 12'd0, 1'b0, 4'd0, 2'd2, 1'b0);
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        check("pri_pause_state", 32'(state), 32'(S_PAUSE));
        apply(1, 1, 0, 0);
        check_all("pri_pause", S_IDLE, 12'd0, 1'b0, 4'd0, 2'd2, 1'b0);

        // Asynchronous reset mid-PLAY at beat 20.
        apply(1, 0, 0, 0);
        run(160);
        check_all("pre_rst", S_PLAY, 12'd20, 1'b1, 4'd5, 2'd2, 1'b0);
        rst = 1'b1;
        #2;
        check_all("async_rst", S_IDLE, 12'd0, 1'b0, 4'd0, 2'd1, 1'b0);
        rst = 1'b0;
        cyc();
        check("post_rst_idle", 32'(state), 32'(S_IDLE));
        apply(1, 0, 0, 0);
        check_all("post_rst_play", S_PLAY, 12'd0, 1'b1, 4'd0, 2'd1, 1'b0);
        run(11);
        check("post_rst_b0", 32'(ibeatNum), 32'd0);
        cyc();
        check("post_rst_b1", 32'(ibeatNum), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/beat_step_sequencer_ctrl.md
# beat_step_sequencer_ctrl

Transport and tempo controller for the 16-step switch-pattern tone datapath. It generates the `ibeatNum` beat index and `en` enable that the tone/LED datapath consumes, four beats per step, 64 beats per pattern. It implements play/pause/stop transport, one-shot or loop playback, and a four-level tempo setting. It sits between the debounced, one-pulsed button logic and the tone datapath.

## Interface
- `BASE_DIV`, default 25_000_000: clock cycles per beat at the fastest tempo. Simulation uses 4.
- `BEAT_COUNT`, default 64: beats per pattern. The last valid beat is `BEAT_COUNT`-1.

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `play_btn`  in  1  single-cycle pulse; start / pause / resume
- `stop_btn`  in  1  single-cycle pulse; stop and rewind
- `tempo_up`  in  1  single-cycle pulse; faster tempo
- `tempo_dn`  in  1  single-cycle pulse; slower tempo
- `loop_mode`  in  1  level; 1 = wrap to beat 0 at pattern end, 0 = one-shot
- `ibeatNum`  out  12  beat index to the datapath
- `en`  out  1  datapath play enable
- `step`  out  4  current step, = `ibeatNum[5:2]`; forced to 0 in END
- `tempo`  out  2  tempo level, 0 = slowest, 3 = fastest
- `state`  out  2  IDLE=00, PLAY=01, PAUSE=10, END=11
- `done`  out  1  single-cycle pattern-complete pulse

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `ibeatNum`=0, `en`=0, `step`=0, `tempo`=1, `done`=0, internal prescaler=0.
- Beat divisor: D = `BASE_DIV`×(4−`tempo`). Tempo 0 gives 4×`BASE_DIV`, tempo 3 gives `BASE_DIV`. The divisor is 32 bits wide.
- **IDLE** (`en`=0, `ibeatNum`=0)
  - `play_btn` → PLAY; prescaler cleared.
- **PLAY** (`en`=1)
  - The prescaler increments every cycle.
  - When prescaler ≥ D−1, this is a tick: prescaler clears and the beat advances.
  - Advance below the last beat: `ibeatNum`+1.
  - Advance at the last beat with `loop_mode`=1: `ibeatNum`→0, stay in PLAY, pulse `done`.
  - Advance at the last beat with `loop_mode`=0: → END, `ibeatNum`=`BEAT_COUNT`, pulse `done`.
  - `play_btn` → PAUSE.
- **PAUSE** (`en`=0)
  - `ibeatNum` and the prescaler are frozen.
  - `play_btn` → PLAY. Resume continues the remaining prescaler count; the prescaler is not cleared.
- **END** (`en`=1, `ibeatNum`=`BEAT_COUNT`)
  - Holding this value drives the datapath's all-LED / silence region.
  - `play_btn` → PLAY from beat 0, prescaler cleared.
- **Stop, any state:** `stop_btn` → IDLE, `ibeatNum`=0, prescaler cleared.
- **Priority:** `stop_btn` beats `play_btn` in the same cycle. A button arriving in the same cycle as a tick is applied, and the tick's beat advance is discarded.
- **Tempo:**
  - `tempo_up` increments `tempo`, saturating at 3.
  - `tempo_dn` decrements `tempo`, saturating at 0.
  - Both asserted in the same cycle: no change.
  - Tempo is accepted in every state.
  - The new D applies from the next cycle. The ≥ compare guarantees an immediate tick if the prescaler already exceeds the new D−1; no overshoot.
- `loop_mode` is sampled only at the last-beat tick.

## Timing
- `play_btn` sampled at edge N (from IDLE or END): `state`=PLAY, `en`=1, `ibeatNum`=0 visible after edge N.
  - `ibeatNum` becomes 1 exactly D cycles later.
  - Thereafter `ibeatNum` advances every D cycles.
- Pause and stop act on the edge that samples the pulse. `en` drops in the same cycle the state changes.
- `done` is high for exactly one cycle, coincident with the first cycle of `ibeatNum`=0 (loop) or the first cycle of END.
- `rst` asserted mid-pattern forces all reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after deassertion.
- One-shot pattern length: `BEAT_COUNT`×D cycles from PLAY entry to END entry.

## Test plan
- Reset mid-PLAY at beat 20 → all outputs zero, `tempo`=1, `state`=IDLE. After release, the first `play_btn` starts at beat 0.
- `BASE_DIV`=4, `tempo`=1 (D=12), `loop_mode`=0, `play_btn` → `ibeatNum` 0→1 after 12 cycles, `step`=1 at beat 4. After 768 cycles: `state`=END, `ibeatNum`=64, `en`=1, one-cycle `done`.
- Pause at beat 5, prescaler=7; hold 100 cycles → `en`=0, `ibeatNum` stays 5. `play_btn` → beat 6 exactly 5 cycles after resume.
- `loop_mode`=1, run through beat 63 → `ibeatNum`=0, `state`=PLAY, one-cycle `done`, `en` never drops.
- Tempo:
  - 3× `tempo_up` → `tempo`=3, saturated; beats every 4 cycles.
  - `tempo_up`+`tempo_dn` together → no change.
  - 5× `tempo_dn` → `tempo`=0; beats every 16 cycles.
  - `tempo_up` at prescaler=10 with D 12→8 → tick on the next cycle.
- `play_btn`+`stop_btn` in the same cycle during PLAY at beat 30 → IDLE, `ibeatNum`=0, `en`=0. The same pair in PAUSE → IDLE.
